// File: rtl/fp64_pkg.sv
// +----------------------------------------------------------------------+
// | fp64_pkg                                                             |
// | Shared binary64 field widths, bias and field-slice helpers.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fp64_pkg;

   localparam int FP64_EXP_W  = 11;
   localparam int FP64_FRAC_W = 52;
   localparam int FP64_BIAS   = 1023;
   localparam int EXP_MAX     = (1 << FP64_EXP_W) - 1;

   function automatic logic fp64_sign(input logic [63:0] x);
      return x[FP64_EXP_W + FP64_FRAC_W];
   endfunction

   function automatic logic [FP64_EXP_W-1:0] fp64_exp(input logic [63:0] x);
      return x[FP64_EXP_W + FP64_FRAC_W - 1 : FP64_FRAC_W];
   endfunction

   function automatic logic [FP64_FRAC_W-1:0] fp64_frac(input logic [63:0] x);
      return x[FP64_FRAC_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_step_restoring.sv
// +----------------------------------------------------------------------+
// | div_step_restoring                                                   |
// | One restoring-division step: quotient bit and shifted remainder.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module div_step_restoring #(
   parameter int WIDTH = 55
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem_next,
   output logic             o_q_bit
);

   assign o_q_bit    = (i_rem >= i_div);
   // The bit shifted out is always zero: after a restore the remainder is below the divisor.
   assign o_rem_next = (o_q_bit ? (i_rem - i_div) : i_rem) << 1;

endmodule

`default_nettype wire

// File: rtl/div_fp64_seq.sv
// +----------------------------------------------------------------------+
// | div_fp64_seq                                                         |
// | Iterative binary64 divider, one restoring quotient bit per cycle.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module div_fp64_seq
   import fp64_pkg::*;
#(
   parameter int EXP_W  = FP64_EXP_W,
   parameter int FRAC_W = FP64_FRAC_W,
   parameter int BIAS   = FP64_BIAS
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_valid,
   output logic        O_ready,
   input  logic [63:0] I_a,
   input  logic [63:0] I_b,
   output logic        O_valid,
   input  logic        I_ready,
   output logic [63:0] O_result,
   output logic        O_over_flow,
   output logic        O_div_by_zero
);

   localparam int          c_EW       = EXP_W + 2;
   localparam int          c_QW       = FRAC_W + 2;
   localparam int          c_RW       = FRAC_W + 3;
   localparam logic [5:0]  c_CNT_INIT = 6'(FRAC_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_valid;
   logic              r_special;
   logic              r_sign;
   logic [c_EW-1:0]   r_exp;
   logic [c_RW-1:0]   r_rem;
   logic [c_RW-1:0]   r_div;
   logic [c_QW-1:0]   r_q;
   logic [5:0]        r_cnt;
   logic [63:0]       r_result;
   logic              r_ovf;
   logic              r_dbz;

   logic [EXP_W-1:0]  w_a_exp;
   logic [EXP_W-1:0]  w_b_exp;
   logic [FRAC_W-1:0] w_a_frac;
   logic [FRAC_W-1:0] w_b_frac;
   logic              w_sign;
   logic              w_b_zero;
   logic [c_EW-1:0]   w_exp_init;
   logic [c_RW-1:0]   w_rem_next;
   logic              w_q_bit;
   logic              w_norm_hi;
   logic [FRAC_W-1:0] w_frac_fin;
   logic [c_EW-1:0]   w_exp_fin;
   logic              w_ovf;

   assign w_a_exp    = fp64_exp(I_a);
   assign w_b_exp    = fp64_exp(I_b);
   assign w_a_frac   = fp64_frac(I_a);
   assign w_b_frac   = fp64_frac(I_b);
   assign w_sign     = fp64_sign(I_a) ^ fp64_sign(I_b);
   assign w_b_zero   = (w_b_exp == '0) && (w_b_frac == '0);
   // Two's-complement wrap in c_EW bits keeps the exponent signed.
   assign w_exp_init = {2'b00, w_a_exp} - {2'b00, w_b_exp} + c_EW'(BIAS);

   div_step_restoring #(
      .WIDTH (c_RW)
   ) u_step (
      .i_rem      (r_rem),
      .i_div      (r_div),
      .o_rem_next (w_rem_next),
      .o_q_bit    (w_q_bit)
   );

   // Quotient lies in (0.5, 2): a clear top bit means one extra left shift.
   assign w_norm_hi  = r_q[c_QW-1];
   assign w_frac_fin = w_norm_hi ? r_q[c_QW-2:1] : r_q[c_QW-3:0];
   assign w_exp_fin  = w_norm_hi ? r_exp : (r_exp - c_EW'(1));
   assign w_ovf      = |w_exp_fin[c_EW-1:EXP_W];

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_state   <= IDLE;
         r_valid   <= 1'b0;
         r_special <= 1'b0;
         r_sign    <= 1'b0;
         r_exp     <= '0;
         r_rem     <= '0;
         r_div     <= '0;
         r_q       <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_ovf     <= 1'b0;
         r_dbz     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (I_valid) begin
                  r_sign    <= w_sign;
                  r_ovf     <= 1'b0;
                  r_dbz     <= 1'b0;
                  r_special <= 1'b1;
                  if (w_b_zero) begin
                     r_result <= {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                     r_dbz    <= 1'b1;
                     r_state  <= DONE;
                  end else if (w_a_exp == '0) begin
                     r_result <= {w_sign, {(EXP_W + FRAC_W){1'b0}}};
                     r_state  <= DONE;
                  end else begin
                     r_special <= 1'b0;
                     r_exp     <= w_exp_init;
                     r_rem     <= {2'b00, 1'b1, w_a_frac};
                     r_div     <= {2'b00, 1'b1, w_b_frac};
                     r_q       <= '0;
                     r_cnt     <= c_CNT_INIT;
                     r_state   <= CALC;
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_next;
               r_q   <= {r_q[c_QW-2:0], w_q_bit};
               r_cnt <= r_cnt - 6'd1;
               if (r_cnt == '0) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; later cycles wait for the consumer.
               if (!r_valid) begin
                  r_valid <= 1'b1;
                  if (!r_special) begin
                     r_result <= {r_sign, w_exp_fin[EXP_W-1:0], w_frac_fin};
                     r_ovf    <= w_ovf;
                  end
               end else if (I_ready) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign O_ready       = (r_state == IDLE);
   assign O_valid       = r_valid;
   assign O_result      = r_result;
   assign O_over_flow   = r_ovf;
   assign O_div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_div_fp64_seq.sv
// +----------------------------------------------------------------------+
// | tb_div_fp64_seq                                                      |
// | Directed self-checking bench for div_fp64_seq with a reference model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_div_fp64_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        out_valid;
   logic        in_ready;
   logic [63:0] out_result;
   logic        out_ovf;
   logic        out_dbz;

   int          n_checks;
   int          n_errors;
   logic        chk_en;
   logic        m_pending;
   logic [63:0] m_res;
   logic        m_ovf;
   logic        m_dbz;

   div_fp64_seq dut (
      .I_clk         (clk),
      .I_rst         (rst),
      .I_valid       (in_valid),
      .O_ready       (out_ready),
      .I_a           (in_a),
      .I_b           (in_b),
      .O_valid       (out_valid),
      .I_ready       (in_ready),
      .O_result      (out_result),
      .O_over_flow   (out_ovf),
      .O_div_by_zero (out_dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: event did not occur as required", nm);
   endtask

   // Quotient from wide integer division of the significands, then the IEEE field rules.
   function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output logic ovf, output logic dbz);
      logic         s;
      int           e;
      logic [127:0] ma, mb, q;
      logic [51:0]  frac;
      s   = a[63] ^ b[63];
      ovf = 1'b0;
      dbz = 1'b0;
      if (b[62:0] == 63'd0) begin
         res = {s, 11'h7FF, 52'h0};
         dbz = 1'b1;
      end else if (a[62:52] == 11'd0) begin
         res = {s, 63'h0};
      end else begin
         ma = {75'd0, 1'b1, a[51:0]};
         mb = {75'd0, 1'b1, b[51:0]};
         q  = (ma << 53) / mb;
         e  = int'(a[62:52]) - int'(b[62:52]) + 1023;
         if (q[53]) begin
            frac = q[52:1];
         end else begin
            frac = q[51:0];
            e    = e - 1;
         end
         ovf = (e < 0) || (e > 2047);
         res = {s, e[10:0], frac};
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("ready_vs_idle", {63'd0, out_ready}, {63'd0, !m_pending});
         if (out_valid) begin
            if (!m_pending) begin
               fail_now("spurious_valid");
            end else begin
               chk("cmp_result", out_result, m_res);
               chk("cmp_ovf", {63'd0, out_ovf}, {63'd0, m_ovf});
               chk("cmp_dbz", {63'd0, out_dbz}, {63'd0, m_dbz});
            end
         end
      end
   end

   task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] lit_res, input logic lit_ovf, input logic lit_dbz,
                         input int lit_lat, input int hold);
      int lat;
      int guard;
      guard = 0;
      while (out_ready !== 1'b1 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (out_ready !== 1'b1) begin
         fail_now({nm, "_ready_timeout"});
         return;
      end
      model(a, b, m_res, m_ovf, m_dbz);
      chk({nm, "_model_res"}, m_res, lit_res);
      chk({nm, "_model_flags"}, {62'd0, m_ovf, m_dbz}, {62'd0, lit_ovf, lit_dbz});
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      m_pending = 1'b1;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid !== 1'b1) begin
         fail_now({nm, "_valid_timeout"});
         return;
      end
      chk({nm, "_latency"}, 64'(lat), 64'(lit_lat));
      chk({nm, "_result"}, out_result, lit_res);
      chk({nm, "_flags"}, {62'd0, out_ovf, out_dbz}, {62'd0, lit_ovf, lit_dbz});
      // Backpressure: offer new operands while the result is held.
      for (int i = 0; i < hold; i++) begin
         in_a     = 64'h3FF0000000000000;
         in_b     = 64'h4008000000000000;
         in_valid = i[0];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (hold > 0) begin
         chk({nm, "_held_result"}, out_result, lit_res);
         chk({nm, "_held_ready"}, {63'd0, out_ready}, 64'd0);
      end
      in_ready = 1'b1;
      @(posedge clk); #1;
      in_ready  = 1'b0;
      m_pending = 1'b0;
      chk({nm, "_post_ready"}, {63'd0, out_ready}, 64'd1);
      chk({nm, "_post_valid"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      chk_en    = 1'b0;
      m_pending = 1'b0;
      m_res     = '0;
      m_ovf     = 1'b0;
      m_dbz     = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_ready  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_ready", {63'd0, out_ready}, 64'd1);
      chk("reset_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_result", out_result, 64'd0);
      chk("reset_flags", {62'd0, out_ovf, out_dbz}, 64'd0);
      chk_en = 1'b1;

      run_op("six_by_two",   64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 1'b0, 1'b0, 55, 0);
      run_op("one_by_three", 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 1'b0, 1'b0, 55, 0);
      run_op("div_zero",     64'hBFF0000000000000, 64'h0000000000000000, 64'hFFF0000000000000, 1'b0, 1'b1, 1, 0);
      run_op("ovf_high",     64'h7FE0000000000000, 64'h3FD0000000000000, 64'h0000000000000000, 1'b1, 1'b0, 55, 0);
      run_op("ovf_low",      64'h0010000000000000, 64'h7FE0000000000000, 64'h4020000000000000, 1'b1, 1'b0, 55, 0);
      run_op("exp_max",      64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, 1'b0, 1'b0, 55, 0);
      run_op("a_zero",       64'h8000000000000000, 64'h3FF0000000000000, 64'h8000000000000000, 1'b0, 1'b0, 1, 0);
      run_op("zero_by_zero", 64'h0000000000000000, 64'h8000000000000000, 64'hFFF0000000000000, 1'b0, 1'b1, 1, 0);
      run_op("b_exp0",       64'h3FF0000000000000, 64'h0008000000000000, 64'h7FD5555555555555, 1'b0, 1'b0, 55, 0);
      run_op("neg_mixed",    64'hC00C000000000000, 64'h3FF8000000000000, 64'hC002AAAAAAAAAAAA, 1'b0, 1'b0, 55, 0);
      run_op("backpressure", 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 1'b0, 1'b0, 55, 10);

      // Abort an operation mid-iteration with reset.
      in_a     = 64'h4018000000000000;
      in_b     = 64'h4000000000000000;
      in_valid = 1'b1;
      model(in_a, in_b, m_res, m_ovf, m_dbz);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      m_pending = 1'b1;
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      m_pending = 1'b0;
      chk("abort_ready", {63'd0, out_ready}, 64'd1);
      chk("abort_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_result", out_result, 64'd0);
      chk("abort_flags", {62'd0, out_ovf, out_dbz}, 64'd0);
      repeat (60) @(posedge clk);
      #1;
      chk("abort_no_late_valid", {63'd0, out_valid}, 64'd0);

      run_op("one_by_one",   64'h3FF0000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1'b0, 55, 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
